// File: rtl/rom_loader.sv
// rom_loader: runtime program loader. Parses a framed byte stream
// (0xA5, CNT_L, CNT_H, 4*N little-endian data bytes, 8-bit checksum) and
// writes 32-bit words into the instruction ROM write port. The core is held
// in reset while a frame is being loaded or after a failed load.
module rom_loader #(
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 4096,
   parameter int TIMEOUT   = 65535,
   parameter int BOOT_HOLD = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_waddr,
   output logic [31:0]       rom_wdata,
   output logic              core_rst_n,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   localparam int             TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TLAST     = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TONE      = TW'(1);
   localparam logic           CORE_IDLE = (BOOT_HOLD == 0) ? 1'b1 : 1'b0;
   localparam logic [16:0]    DEPTH_W   = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN0 = 3'd1,
      S_LEN1 = 3'd2,
      S_DATA = 3'd3,
      S_CSUM = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   // Running modulo-256 checksum step.
   function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
      return 8'(s + b);
   endfunction

   state_t              state_r, state_s;
   logic [7:0]          cnt_l_r, cnt_l_s;
   logic [15:0]         n_r, n_s;
   logic [1:0]          idx_r, idx_s;
   logic [23:0]         word_r, word_s;
   logic [7:0]          sum_r, sum_s;
   logic [15:0]         widx_r, widx_s;
   logic [TW-1:0]       timer_r, timer_s;
   logic                we_r, we_s;
   logic [ADDR_W-1:0]   waddr_r, waddr_s;
   logic [31:0]         wdata_r, wdata_s;
   logic                done_r, done_s;
   logic                err_r, err_s;
   logic [15:0]         words_r, words_s;
   logic                core_r, core_s;
   logic                acc_s;
   logic                in_frame_s;
   logic [15:0]         n_full_s;

   // The loader never back-pressures the byte source.
   assign in_ready = 1'b1;
   assign acc_s    = in_valid;
   assign n_full_s = {in_data, cnt_l_r};

   // Next-state, datapath and frame timeout decisions.
   always_comb begin
      state_s    = state_r;
      cnt_l_s    = cnt_l_r;
      n_s        = n_r;
      idx_s      = idx_r;
      word_s     = word_r;
      sum_s      = sum_r;
      widx_s     = widx_r;
      timer_s    = timer_r;
      we_s       = 1'b0;
      waddr_s    = waddr_r;
      wdata_s    = wdata_r;
      done_s     = done_r;
      err_s      = err_r;
      words_s    = words_r;
      in_frame_s = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (acc_s && (in_data == 8'hA5)) begin
               state_s = S_LEN0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LEN0: begin
            in_frame_s = 1'b1;
            if (acc_s) begin
               cnt_l_s = in_data;
               sum_s   = 8'd0;
               words_s = 16'd0;
               idx_s   = 2'd0;
               widx_s  = 16'd0;
               done_s  = 1'b0;
               err_s   = 1'b0;
               state_s = S_LEN1;
            end else begin
               state_s = S_LEN0;
            end
         end
         S_LEN1: begin
            in_frame_s = 1'b1;
            if (acc_s) begin
               n_s = n_full_s;
               if (n_full_s == 16'd0) begin
                  state_s = S_CSUM;
               end else if ({1'b0, n_full_s} > DEPTH_W) begin
                  state_s = S_ERR;
                  err_s   = 1'b1;
                  done_s  = 1'b0;
               end else begin
                  state_s = S_DATA;
               end
            end else begin
               state_s = S_LEN1;
            end
         end
         S_DATA: begin
            in_frame_s = 1'b1;
            if (acc_s) begin
               sum_s = csum_add(sum_r, in_data);
               idx_s = idx_r + 2'd1;
               case (idx_r)
                  2'd0: word_s[7:0]   = in_data;
                  2'd1: word_s[15:8]  = in_data;
                  2'd2: word_s[23:16] = in_data;
                  2'd3: begin
                     we_s    = 1'b1;
                     waddr_s = widx_r[ADDR_W-1:0];
                     wdata_s = {in_data, word_r};
                     widx_s  = widx_r + 16'd1;
                     words_s = (words_r == 16'hFFFF) ? words_r : (words_r + 16'd1);
                     if (widx_r == (n_r - 16'd1)) begin
                        state_s = S_CSUM;
                     end else begin
                        state_s = S_DATA;
                     end
                  end
                  default: word_s = word_r;
               endcase
            end else begin
               state_s = S_DATA;
            end
         end
         S_CSUM: begin
            in_frame_s = 1'b1;
            if (acc_s) begin
               if (in_data == sum_r) begin
                  state_s = S_DONE;
                  done_s  = 1'b1;
                  err_s   = 1'b0;
               end else begin
                  state_s = S_ERR;
                  done_s  = 1'b0;
                  err_s   = 1'b1;
               end
            end else begin
               state_s = S_CSUM;
            end
         end
         S_DONE, S_ERR: begin
            if (acc_s && (in_data == 8'hA5)) begin
               state_s = S_LEN0;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      // Idle-gap watchdog inside a frame; an expiry overrides the parser.
      if (in_frame_s) begin
         if (acc_s) begin
            timer_s = '0;
         end else if (timer_r == TLAST) begin
            timer_s = '0;
            state_s = S_ERR;
            err_s   = 1'b1;
            done_s  = 1'b0;
         end else begin
            timer_s = timer_r + TONE;
         end
      end else begin
         timer_s = '0;
      end

      // Core reset follows the current state, so it lags a state change by one cycle.
      if (state_r == S_DONE) begin
         core_s = 1'b1;
      end else if (state_r == S_IDLE) begin
         core_s = CORE_IDLE;
      end else begin
         core_s = 1'b0;
      end
   end

   // Parser state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath, status and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_l_r <= 8'd0;
         n_r     <= 16'd0;
         idx_r   <= 2'd0;
         word_r  <= 24'd0;
         sum_r   <= 8'd0;
         widx_r  <= 16'd0;
         timer_r <= '0;
         we_r    <= 1'b0;
         waddr_r <= '0;
         wdata_r <= 32'd0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         words_r <= 16'd0;
         core_r  <= CORE_IDLE;
      end else begin
         cnt_l_r <= cnt_l_s;
         n_r     <= n_s;
         idx_r   <= idx_s;
         word_r  <= word_s;
         sum_r   <= sum_s;
         widx_r  <= widx_s;
         timer_r <= timer_s;
         we_r    <= we_s;
         waddr_r <= waddr_s;
         wdata_r <= wdata_s;
         done_r  <= done_s;
         err_r   <= err_s;
         words_r <= words_s;
         core_r  <= core_s;
      end
   end

   assign rom_we       = we_r;
   assign rom_waddr    = waddr_r;
   assign rom_wdata    = wdata_r;
   assign core_rst_n   = core_r;
   assign load_done    = done_r;
   assign load_err     = err_r;
   assign words_loaded = words_r;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: frames are generated at the byte
// level, the expected ROM writes and status come from the frame contents.
module tb_rom_loader;

   localparam int AW = 4;
   localparam int DP = 16;
   localparam int TO = 40;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready,  in_ready0;
   logic              rom_we,    rom_we0;
   logic [AW-1:0]     rom_waddr, rom_waddr0;
   logic [31:0]       rom_wdata, rom_wdata0;
   logic              core_rst_n, core_rst_n0;
   logic              load_done, load_done0;
   logic              load_err,  load_err0;
   logic [15:0]       words_loaded, words_loaded0;

   int checks   = 0;
   int failures = 0;

   logic [7:0]     frm[$];
   logic [31:0]    ew[$];
   logic [AW+31:0] got[$];
   bit             gaps;

   rom_loader #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO), .BOOT_HOLD(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rom_we(rom_we), .rom_waddr(rom_waddr),
      .rom_wdata(rom_wdata), .core_rst_n(core_rst_n), .load_done(load_done),
      .load_err(load_err), .words_loaded(words_loaded)
   );

   rom_loader #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO), .BOOT_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .rom_we(rom_we0), .rom_waddr(rom_waddr0),
      .rom_wdata(rom_wdata0), .core_rst_n(core_rst_n0), .load_done(load_done0),
      .load_err(load_err0), .words_loaded(words_loaded0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every ROM write, sampled mid-cycle.
   always @(negedge clk) begin
      if (rom_we) got.push_back({rom_waddr, rom_wdata});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Random frame of n words; optionally biased towards 0xA5 data bytes.
   task automatic build(input int n, input bit bad, input bit a5);
      logic [31:0] w;
      logic [7:0]  sum;
      logic [7:0]  b;
      frm.delete();
      ew.delete();
      frm.push_back(8'hA5);
      frm.push_back(8'(n));
      frm.push_back(8'(n >> 8));
      sum = 8'd0;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         if (a5 && ($urandom_range(0, 2) == 0)) w[7:0]   = 8'hA5;
         if (a5 && ($urandom_range(0, 2) == 0)) w[23:16] = 8'hA5;
         ew.push_back(w);
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            frm.push_back(b);
            sum = 8'(sum + b);
         end
      end
      if (bad) sum = 8'(sum + 8'd1 + 8'($urandom_range(0, 254)));
      frm.push_back(sum);
   endtask

   task automatic send_frame();
      got.delete();
      for (int i = 0; i < frm.size(); i++) begin
         if (gaps && (i > 0)) idle($urandom_range(0, 3));
         send_byte(frm[i]);
      end
   endtask

   task automatic expect_result(input string tag, input int nwords, input bit ok);
      idle(3);
      check({tag, ":writes"}, got.size(), ew.size());
      for (int i = 0; (i < got.size()) && (i < ew.size()); i++) begin
         check({tag, ":addr"}, got[i][AW+31:32], i);
         check({tag, ":data"}, got[i][31:0], ew[i]);
      end
      check({tag, ":done"},  load_done, ok);
      check({tag, ":err"},   load_err, !ok);
      check({tag, ":words"}, words_loaded, nwords);
      check({tag, ":core"},  core_rst_n, ok);
      check({tag, ":rdy"},   in_ready, 1'b1);
      check({tag, ":done0"}, load_done0, ok);
      check({tag, ":core0"}, core_rst_n0, ok);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      gaps     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst:we", rom_we, 1'b0);
      check("rst:waddr", rom_waddr, 0);
      check("rst:wdata", rom_wdata, 0);
      check("rst:done", load_done, 1'b0);
      check("rst:err", load_err, 1'b0);
      check("rst:words", words_loaded, 0);
      check("rst:core", core_rst_n, 1'b0);
      check("rst:core0", core_rst_n0, 1'b1);
      check("rst:rdy", in_ready, 1'b1);
      rst = 1'b1;
      idle(3);
      check("idle:core", core_rst_n, 1'b0);
      check("idle:core0", core_rst_n0, 1'b1);

      // Directed two-word frame with a good checksum.
      frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      ew  = {32'h00000013, 32'h00100093};
      send_frame();
      expect_result("s1", 2, 1'b1);

      // Same frame, checksum off by one: words still written.
      frm[11] = 8'hB7;
      send_frame();
      expect_result("s2", 2, 1'b0);

      // Leading garbage, then the good frame.
      frm[11] = 8'hB6;
      frm.push_front(8'h5A);
      frm.push_front(8'hFF);
      frm.push_front(8'h00);
      send_frame();
      expect_result("s3", 2, 1'b1);

      // Oversized count, then recovery with a single word.
      frm = {8'hA5, 8'h01, 8'h10};
      ew.delete();
      send_frame();
      expect_result("ovf", 0, 1'b0);
      frm = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
      ew  = {32'hDEADBEEF};
      send_frame();
      expect_result("s4", 1, 1'b1);

      // Stall mid-word: no error one cycle short of the limit, error at it.
      frm = {8'hA5, 8'h01, 8'h00, 8'hEF};
      send_frame();
      idle(TO - 1);
      check("to:early_err", load_err, 1'b0);
      idle(1);
      check("to:err", load_err, 1'b1);
      idle(2);
      check("to:writes", got.size(), 0);
      check("to:core", core_rst_n, 1'b0);
      check("to:done", load_done, 1'b0);

      // Empty frames: zero words, checksum must be zero.
      frm = {8'hA5, 8'h00, 8'h00, 8'h00};
      ew.delete();
      send_frame();
      expect_result("n0", 0, 1'b1);
      frm = {8'hA5, 8'h00, 8'h00, 8'h01};
      send_frame();
      expect_result("n0bad", 0, 1'b0);

      // Largest and one-past-largest word counts.
      gaps = 1'b1;
      build(DP, 1'b0, 1'b1);
      send_frame();
      expect_result("nmax", DP, 1'b1);
      frm = {8'hA5, 8'(DP + 1), 8'h00};
      ew.delete();
      send_frame();
      expect_result("nmax1", 0, 1'b0);

      // Random frames, random gaps, 0xA5 inside data.
      for (int f = 0; f < 10; f++) begin
         int  n;
         bit  bad;
         n   = $urandom_range(1, 8);
         bad = ($urandom_range(0, 3) == 0);
         gaps = ($urandom_range(0, 1) == 1);
         build(n, bad, 1'b1);
         send_frame();
         expect_result($sformatf("rnd%0d", f), n, !bad);
      end

      // Reset in the middle of the second word.
      gaps = 1'b0;
      build(3, 1'b0, 1'b0);
      got.delete();
      for (int i = 0; i < 9; i++) send_byte(frm[i]);
      idle(1);
      check("mid:partial", got.size(), 1);
      check("mid:words_pre", words_loaded, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid:we", rom_we, 1'b0);
      check("mid:waddr", rom_waddr, 0);
      check("mid:wdata", rom_wdata, 0);
      check("mid:done", load_done, 1'b0);
      check("mid:err", load_err, 1'b0);
      check("mid:words", words_loaded, 0);
      check("mid:core", core_rst_n, 1'b0);
      check("mid:core0", core_rst_n0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      build(4, 1'b0, 1'b1);
      send_frame();
      expect_result("post", 4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
